// File: rtl/dma_bus_master_pkg.sv
// Shared definitions for the Data_Bus/Address_Bus initiator: bus defaults,
// control encoding and the DMA sequencer state set.
package dma_bus_master_pkg;

    localparam int unsigned BUS_ADDR_W = 16;
    localparam int unsigned BUS_DATA_W = 32;

    localparam logic CTRL_READ  = 1'b0;
    localparam logic CTRL_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARB    = 3'd1,
        ST_RD_REQ = 3'd2,
        ST_RD_ACK = 3'd3,
        ST_WR_REQ = 3'd4,
        ST_WR_ACK = 3'd5,
        ST_DONE   = 3'd6
    } dma_state_e;

    // States in which the initiator owns the bus and waits on TReady.
    function automatic logic is_xfer_state(input dma_state_e s);
        return (s == ST_RD_REQ) || (s == ST_RD_ACK) ||
               (s == ST_WR_REQ) || (s == ST_WR_ACK);
    endfunction

endpackage

// File: rtl/dma_timeout_ctr.sv
// Per-state cycle counter; restarts on load and flags when TIMEOUT is reached.
module dma_timeout_ctr #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_enable,
    output logic o_expired_c
);

    localparam int unsigned CTR_W = $clog2(TIMEOUT + 1);

    logic [CTR_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_load) begin
            r_cnt <= '0;
        end else if (i_enable && !o_expired_c) begin
            r_cnt <= r_cnt + CTR_W'(1);
        end
    end

    assign o_expired_c = (r_cnt == CTR_W'(TIMEOUT));

endmodule

// File: rtl/dma_bus_master.sv
// Memory-to-memory block copy engine acting as initiator on the shared
// four-phase IReady/TReady bus; ownership is requested through bus_req/bus_gnt.
module dma_bus_master
    import dma_bus_master_pkg::*;
#(
    parameter int unsigned ADDR_W  = BUS_ADDR_W,
    parameter int unsigned DATA_W  = BUS_DATA_W,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              bus_req,
    input  logic              bus_gnt,
    inout  logic [ADDR_W-1:0] Address_Bus,
    inout  logic [DATA_W-1:0] Data_Bus,
    inout  logic              Control,
    inout  logic              IReady,
    input  logic              TReady
);

    dma_state_e        r_state;
    dma_state_e        w_state_next;
    logic              w_timeout;
    logic              w_expired_c;
    logic              w_to_load;
    logic              w_to_enable;

    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [CNT_W-1:0]  r_rem;
    logic [DATA_W-1:0] r_data;
    logic              r_error;

    logic              w_busy, w_done, w_bus_req, w_own, w_drv_data, w_ctrl, w_irdy;
    logic [ADDR_W-1:0] w_addr;
    logic              r_busy, r_done, r_bus_req, r_own, r_drv_data, r_ctrl, r_irdy;
    logic [ADDR_W-1:0] r_addr;

    assign w_to_load   = (w_state_next != r_state);
    assign w_to_enable = is_xfer_state(r_state);

    dma_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_to_load),
        .i_enable   (w_to_enable),
        .o_expired_c(w_expired_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state; TReady wins over a timeout that expires on the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = (count != '0) ? ST_ARB : ST_DONE;
                end
            end
            ST_ARB: begin
                if (bus_gnt) begin
                    w_state_next = ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                if (TReady) begin
                    w_state_next = ST_RD_ACK;
                end else if (w_expired_c) begin
                    w_state_next = ST_DONE;
                    w_timeout    = 1'b1;
                end
            end
            ST_RD_ACK: begin
                if (!TReady) begin
                    w_state_next = ST_WR_REQ;
                end else if (w_expired_c) begin
                    w_state_next = ST_DONE;
                    w_timeout    = 1'b1;
                end
            end
            ST_WR_REQ: begin
                if (TReady) begin
                    w_state_next = ST_WR_ACK;
                end else if (w_expired_c) begin
                    w_state_next = ST_DONE;
                    w_timeout    = 1'b1;
                end
            end
            ST_WR_ACK: begin
                if (!TReady) begin
                    w_state_next = (r_rem == CNT_W'(1)) ? ST_DONE : ST_RD_REQ;
                end else if (w_expired_c) begin
                    w_state_next = ST_DONE;
                    w_timeout    = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Bus drive set derived from the current state, registered below.
    always_comb begin
        w_busy     = (r_state != ST_IDLE);
        w_done     = (r_state == ST_DONE);
        w_bus_req  = (r_state == ST_ARB) || is_xfer_state(r_state);
        w_own      = is_xfer_state(r_state);
        w_drv_data = (r_state == ST_WR_REQ) || (r_state == ST_WR_ACK);
        w_ctrl     = w_drv_data ? CTRL_WRITE : CTRL_READ;
        w_irdy     = (r_state == ST_RD_REQ) || (r_state == ST_WR_REQ);
        w_addr     = w_drv_data ? r_dst : r_src;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bus_req  <= 1'b0;
            r_own      <= 1'b0;
            r_drv_data <= 1'b0;
            r_ctrl     <= 1'b0;
            r_irdy     <= 1'b0;
            r_addr     <= '0;
        end else begin
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_bus_req  <= w_bus_req;
            r_own      <= w_own;
            r_drv_data <= w_drv_data;
            r_ctrl     <= w_ctrl;
            r_irdy     <= w_irdy;
            r_addr     <= w_addr;
        end
    end

    // Transfer datapath: pointers, remaining count, data word and error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_src   <= '0;
            r_dst   <= '0;
            r_rem   <= '0;
            r_data  <= '0;
            r_error <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && start) begin
                r_error <= 1'b0;
                if (count != '0) begin
                    r_src <= src_addr;
                    r_dst <= dst_addr;
                    r_rem <= count;
                end
            end
            if ((r_state == ST_RD_REQ) && TReady) begin
                r_data <= Data_Bus;
            end
            if ((r_state == ST_WR_ACK) && !TReady) begin
                r_src <= r_src + ADDR_W'(1);
                r_dst <= r_dst + ADDR_W'(1);
                r_rem <= r_rem - CNT_W'(1);
            end
            if (w_timeout) begin
                r_error <= 1'b1;
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;
    assign bus_req     = r_bus_req;
    assign Address_Bus = r_own      ? r_addr : 'z;
    assign Control     = r_own      ? r_ctrl : 1'bz;
    assign IReady      = r_own      ? r_irdy : 1'bz;
    assign Data_Bus    = r_drv_data ? r_data : 'z;

endmodule
